// File: rtl/logic_unit_pkg.sv
// Shared op encodings and the bitwise result function for the logic unit pipeline.
package logic_unit_pkg;

  // Widest operand the result function handles; callers zero-extend and truncate.
  localparam int unsigned MAX_W = 64;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_BUF  = 3'b111;

  function automatic logic [MAX_W-1:0] lu_result(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input logic [2:0]       op);
    logic [MAX_W-1:0] r;
    unique case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_BUF:  r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_fifo.sv
// Generic synchronous FIFO; head data reads as zero while empty.
module logic_unit_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: op result plus zero/parity flags, queued behind valid/ready.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] done_cnt
);

  import logic_unit_pkg::*;

  localparam int unsigned DW = WIDTH + 2;

  logic [WIDTH-1:0] res;
  logic [DW-1:0]    wdata, rdata;
  logic             full, empty;
  logic             accept, take;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  assign res    = WIDTH'(lu_result(MAX_W'(a), MAX_W'(b), op));
  assign wdata  = {res, ~|res, ^res};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  logic_unit_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (wdata),
    .pop   (take),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign {y, zero, parity} = rdata;
  assign done_cnt          = done_cnt_q;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (take) done_cnt_d = done_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) done_cnt_q <= '0;
    else     done_cnt_q <= done_cnt_d;
  end

endmodule
